// File: rtl/mac_accum_pipe.sv
// Pipelined multiply-accumulate stage: operand register, MultN array multiplier,
// product register, then a saturating per-packet accumulator with a valid/ready result port.
module mac_accum_pipe #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat
);

    logic                 en;

    logic [WIDTH-1:0]     a1_q, a1_d;
    logic [WIDTH-1:0]     b1_q, b1_d;
    logic                 last1_q, last1_d;
    logic                 v1_q, v1_d;

    logic [2*WIDTH-1:0]   multP;
    logic [ACC_WIDTH-1:0] prod2_q, prod2_d;
    logic                 last2_q, last2_d;
    logic                 v2_q, v2_d;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 first_q, first_d;
    logic                 satPend_q, satPend_d;

    logic                 outValid_q, outValid_d;
    logic [ACC_WIDTH-1:0] outData_q, outData_d;
    logic                 outSat_q, outSat_d;

    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH:0]   sumWide;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] sumClamp;

    // A held result freezes the whole pipe so no beat is lost or duplicated.
    assign en       = !(outValid_q && !out_ready);
    assign in_ready = en;

    MultN #(.N(WIDTH)) u_mult (
        .a_i (a1_q),
        .b_i (b1_q),
        .p_o (multP)
    );

    always_comb begin
        base     = first_q ? '0 : acc_q;
        sumWide  = {1'b0, base} + {1'b0, prod2_q};
        ovf      = sumWide[ACC_WIDTH];
        sumClamp = ovf ? '1 : sumWide[ACC_WIDTH-1:0];
    end

    always_comb begin
        a1_d       = a1_q;
        b1_d       = b1_q;
        last1_d    = last1_q;
        v1_d       = v1_q;
        prod2_d    = prod2_q;
        last2_d    = last2_q;
        v2_d       = v2_q;
        acc_d      = acc_q;
        first_d    = first_q;
        satPend_d  = satPend_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSat_d   = outSat_q;

        if (clr) begin
            v1_d       = 1'b0;
            v2_d       = 1'b0;
            acc_d      = '0;
            satPend_d  = 1'b0;
            outValid_d = 1'b0;
            first_d    = 1'b1;
        end else if (en) begin
            a1_d    = in_a;
            b1_d    = in_b;
            last1_d = in_last;
            v1_d    = in_valid;

            prod2_d = ACC_WIDTH'(multP);
            last2_d = last1_q;
            v2_d    = v1_q;

            // With en high any held result is being taken this edge, so valid only survives on a new load.
            outValid_d = 1'b0;

            if (v2_q) begin
                if (last2_q) begin
                    outData_d  = sumClamp;
                    outSat_d   = satPend_q | ovf;
                    outValid_d = 1'b1;
                    acc_d      = '0;
                    first_d    = 1'b1;
                    satPend_d  = 1'b0;
                end else begin
                    acc_d     = sumClamp;
                    first_d   = 1'b0;
                    satPend_d = satPend_q | ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q       <= '0;
            b1_q       <= '0;
            last1_q    <= 1'b0;
            v1_q       <= 1'b0;
            prod2_q    <= '0;
            last2_q    <= 1'b0;
            v2_q       <= 1'b0;
            acc_q      <= '0;
            first_q    <= 1'b1;
            satPend_q  <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSat_q   <= 1'b0;
        end else begin
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            last1_q    <= last1_d;
            v1_q       <= v1_d;
            prod2_q    <= prod2_d;
            last2_q    <= last2_d;
            v2_q       <= v2_d;
            acc_q      <= acc_d;
            first_q    <= first_d;
            satPend_q  <= satPend_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSat_q   <= outSat_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_sat   = outSat_q;

endmodule

// Combinational unsigned array multiplier: one shifted partial-product row added per bit of b.
module MultN #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);

    logic [2*N-1:0] rowSum;
    logic [2*N-1:0] rowPP;

    always_comb begin
        rowSum = '0;
        rowPP  = '0;
        for (int i = 0; i < N; i++) begin
            rowPP  = {{N{1'b0}}, a_i & {N{b_i[i]}}} << i;
            rowSum = rowSum + rowPP;
        end
        p_o = rowSum;
    end

endmodule
